// File: rtl/plot_arbiter.sv
// Two-requester cell painter: grants one board cell at a time and scans its pixels to the VGA adapter.
// Define PLOT_ARB_CURSOR_RING_EN to draw the cursor (sel 3) as a border ring only.
module plot_arbiter #(
    parameter int CELL     = 14,
    parameter int X_ORIGIN = 24,
    parameter int Y_ORIGIN = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  x0,
    input  logic [2:0]  y0,
    input  logic [2:0]  x1,
    input  logic [2:0]  y1,
    input  logic [1:0]  sel0,
    input  logic [1:0]  sel1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  x_out,
    output logic [6:0]  y_out,
    output logic [17:0] colour,
    output logic        plot,
    output logic        busy
);

    localparam int CW = $clog2(CELL + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    state_t state, nstate;

    logic          rr, n_rr;
    logic          cid, n_cid;
    logic [2:0]    cx, n_cx;
    logic [2:0]    cy, n_cy;
    logic [1:0]    csel, n_sel;
    logic [CW-1:0] dx, n_dx;
    logic [CW-1:0] dy, n_dy;
    logic          fin, n_fin;

    logic          n_ack0, n_ack1, n_done0, n_done1, n_plot;
    logic [7:0]    n_x;
    logic [6:0]    n_y;
    logic [17:0]   n_col;

    logic          win;
    logic          dx_last, dy_last, border;
    logic [7:0]    px;
    logic [6:0]    py;
    logic [17:0]   fill, pcol;
    logic          draw_px;

    assign busy    = (state != IDLE);
    assign dx_last = (dx == CW'(CELL - 1));
    assign dy_last = (dy == CW'(CELL - 1));
    assign border  = (dx == '0) || (dy == '0) || dx_last || dy_last;

    assign px = 8'(X_ORIGIN + int'(cx) * CELL + int'(dx));
    assign py = 7'(Y_ORIGIN + int'(cy) * CELL + int'(dy));

    always_comb begin
        fill    = 18'h00FC0;
        draw_px = 1'b1;
        unique case (csel)
            2'd0: fill = 18'h00FC0;
            2'd1: fill = 18'h00000;
            2'd2: fill = 18'h3FFFF;
            2'd3: fill = 18'h3FFC0;
        endcase
        pcol = border ? 18'h00000 : fill;
`ifdef PLOT_ARB_CURSOR_RING_EN
        if (csel == 2'd3) begin
            pcol    = 18'h3FFC0;
            draw_px = border;
        end
`endif
    end

    always_comb begin
        nstate  = state;
        n_rr    = rr;
        n_cid   = cid;
        n_cx    = cx;
        n_cy    = cy;
        n_sel   = csel;
        n_dx    = dx;
        n_dy    = dy;
        n_fin   = fin;
        n_ack0  = 1'b0;
        n_ack1  = 1'b0;
        n_done0 = 1'b0;
        n_done1 = 1'b0;
        n_plot  = 1'b0;
        n_x     = x_out;
        n_y     = y_out;
        n_col   = colour;
        win     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // rr names the requester favoured on a tie
                    win    = (req0 && req1) ? rr : req1;
                    n_rr   = ~win;
                    n_cid  = win;
                    n_cx   = win ? x1 : x0;
                    n_cy   = win ? y1 : y0;
                    n_sel  = win ? sel1 : sel0;
                    n_dx   = '0;
                    n_dy   = '0;
                    n_fin  = 1'b0;
                    n_ack0 = ~win;
                    n_ack1 = win;
                    nstate = DRAW;
                end
            end
            DRAW: begin
                if (fin) begin
                    n_done0 = ~cid;
                    n_done1 = cid;
                    nstate  = DONE;
                end else begin
                    n_plot = draw_px;
                    if (draw_px) begin
                        n_x   = px;
                        n_y   = py;
                        n_col = pcol;
                    end
                    if (dx_last) begin
                        n_dx = '0;
                        if (dy_last) n_fin = 1'b1;
                        else         n_dy  = dy + 1'b1;
                    end else begin
                        n_dx = dx + 1'b1;
                    end
                end
            end
            DONE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr     <= 1'b0;
            cid    <= 1'b0;
            cx     <= '0;
            cy     <= '0;
            csel   <= '0;
            dx     <= '0;
            dy     <= '0;
            fin    <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            plot   <= 1'b0;
            x_out  <= '0;
            y_out  <= '0;
            colour <= '0;
        end else begin
            rr     <= n_rr;
            cid    <= n_cid;
            cx     <= n_cx;
            cy     <= n_cy;
            csel   <= n_sel;
            dx     <= n_dx;
            dy     <= n_dy;
            fin    <= n_fin;
            ack0   <= n_ack0;
            ack1   <= n_ack1;
            done0  <= n_done0;
            done1  <= n_done1;
            plot   <= n_plot;
            x_out  <= n_x;
            y_out  <= n_y;
            colour <= n_col;
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// Randomized bench for plot_arbiter against a grant-timeline reference model.
// Honours PLOT_ARB_CURSOR_RING_EN the same way the design does.
module tb_plot_arbiter;

    localparam int CELL = 14;
    localparam int XO   = 24;
    localparam int YO   = 4;
    localparam int C2   = CELL * CELL;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [2:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [1:0]  sel0 = '0, sel1 = '0;
    logic        ack0, ack1, done0, done1, plot, busy;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [17:0] colour;

    always #5 clock = ~clock;

    plot_arbiter #(.CELL(CELL), .X_ORIGIN(XO), .Y_ORIGIN(YO)) dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .sel0(sel0), .sel1(sel1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .x_out(x_out), .y_out(y_out), .colour(colour),
        .plot(plot), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference: a grant at edge gn fixes everything up to edge gn+C2+1.
    int          e = 0;
    int          gn = -1000;
    int          gid = 0;
    bit          rr = 1'b0;
    int          plot_cnt = 0;
    int          exp_cnt = 0;
    logic [7:0]  px [C2];
    logic [6:0]  py [C2];
    logic [17:0] pc [C2];
    bit          pp [C2];
    bit          rnd_mode = 1'b0;
    int          keep_n = 0;
    int          acks [$];

    function automatic logic [17:0] fill_of(input logic [1:0] s);
        case (s)
            2'd0: return 18'h00FC0;
            2'd1: return 18'h00000;
            2'd2: return 18'h3FFFF;
            default: return 18'h3FFC0;
        endcase
    endfunction

    task automatic build(input int cx, input int cy, input logic [1:0] s);
        exp_cnt = 0;
        for (int dy = 0; dy < CELL; dy++) begin
            for (int dx = 0; dx < CELL; dx++) begin
                int i;
                bit b;
                i = dy * CELL + dx;
                b = (dx == 0) || (dy == 0) || (dx == CELL - 1) || (dy == CELL - 1);
                px[i] = 8'(XO + cx * CELL + dx);
                py[i] = 7'(YO + cy * CELL + dy);
                pc[i] = b ? 18'h00000 : fill_of(s);
                pp[i] = 1'b1;
`ifdef PLOT_ARB_CURSOR_RING_EN
                if (s == 2'd3) begin
                    pc[i] = 18'h3FFC0;
                    pp[i] = b;
                end
`endif
                if (pp[i]) exp_cnt++;
            end
        end
    endtask

    task automatic drive();
        bit keep;
        keep = rnd_mode ? ($urandom % 3 == 0) : (acks.size() <= keep_n);
        if (ack0) begin
            if (!keep) req0 = 1'b0;
            else if (rnd_mode) begin
                x0 = 3'($urandom); y0 = 3'($urandom); sel0 = 2'($urandom);
            end
        end else if (rnd_mode && !req0) begin
            x0 = 3'($urandom); y0 = 3'($urandom); sel0 = 2'($urandom);
            req0 = ($urandom % 6 == 0);
        end
        if (ack1) begin
            if (!keep) req1 = 1'b0;
            else if (rnd_mode) begin
                x1 = 3'($urandom); y1 = 3'($urandom); sel1 = 2'($urandom);
            end
        end else if (rnd_mode && !req1) begin
            x1 = 3'($urandom); y1 = 3'($urandom); sel1 = 2'($urandom);
            req1 = ($urandom % 6 == 0);
        end
    endtask

    task automatic step();
        int  idx;
        bit  w;
        bit  eplot;
        @(posedge clock);
        #1;
        e++;
        if (e >= gn + C2 + 3 && (req0 || req1)) begin
            w = (req0 && req1) ? rr : req1;
            rr = !w;
            gn = e;
            gid = int'(w);
            plot_cnt = 0;
            if (w) build(int'(x1), int'(y1), sel1);
            else   build(int'(x0), int'(y0), sel0);
        end
        idx = e - gn - 1;
        eplot = 1'b0;
        if (idx >= 0 && idx < C2) eplot = pp[idx];
        check("ack0", ack0, (e == gn) && (gid == 0));
        check("ack1", ack1, (e == gn) && (gid == 1));
        check("busy", busy, (e >= gn) && (e <= gn + C2 + 1));
        check("plot", plot, eplot);
        check("done0", done0, (e == gn + C2 + 1) && (gid == 0));
        check("done1", done1, (e == gn + C2 + 1) && (gid == 1));
        if (eplot) begin
            check("x_out", x_out, px[idx]);
            check("y_out", y_out, py[idx]);
            check("colour", colour, pc[idx]);
        end
        if (plot) plot_cnt++;
        if (e == gn + C2 + 1) check("npix", plot_cnt, exp_cnt);
        if (ack0 || ack1) acks.push_back(int'(ack1));
        drive();
    endtask

    task automatic run_until_idle(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            if (!req0 && !req1 && e >= gn + C2 + 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", ok, 1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ack"}, {ack1, ack0}, 0);
        check({tag, "_done"}, {done1, done0}, 0);
    endtask

    initial begin
        bit hit;
        #12;
        check_quiet("rst");
        check("rst_xy", {x_out, y_out}, 0);
        check("rst_col", colour, 0);
        @(negedge clock);
        resetn = 1'b1;

        // tie from reset: grants must alternate 0,1,0,1
        req0 = 1'b1; x0 = 3'd1; y0 = 3'd2; sel0 = 2'd1;
        req1 = 1'b1; x1 = 3'd6; y1 = 3'd3; sel1 = 2'd2;
        keep_n = 2;
        run_until_idle(1200);
        check("tie_n", acks.size(), 4);
        for (int k = 0; k < 4; k++)
            check("tie_order", (k < acks.size()) ? acks[k] : 99, k % 2);
        keep_n = 0;

        req1 = 1'b1; x1 = 3'd0; y1 = 3'd0; sel1 = 2'd2;
        run_until_idle(400);
        req0 = 1'b1; x0 = 3'd7; y0 = 3'd7; sel0 = 2'd0;
        run_until_idle(400);
        req0 = 1'b1; x0 = 3'd3; y0 = 3'd5; sel0 = 2'd3;
        run_until_idle(400);
        req1 = 1'b1; x1 = 3'd4; y1 = 3'd0; sel1 = 2'd1;
        run_until_idle(400);

        rnd_mode = 1'b1;
        repeat (8000) step();
        rnd_mode = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        run_until_idle(600);

        // reset in the middle of a draw
        req0 = 1'b1; x0 = 3'd3; y0 = 3'd2; sel0 = 2'd1;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (e == gn + 51) begin
                hit = 1'b1;
                break;
            end
        end
        check("mid_draw_reached", hit, 1);
        resetn = 1'b0;
        #1;
        check_quiet("mid_rst");
        req0 = 1'b1; x0 = 3'd2; y0 = 3'd6; sel0 = 2'd2;
        req1 = 1'b1; x1 = 3'd5; y1 = 3'd1; sel1 = 2'd0;
        gn = -1000;
        rr = 1'b0;
        acks.delete();
        @(negedge clock);
        check_quiet("in_rst");
        @(negedge clock);
        resetn = 1'b1;
        run_until_idle(1200);
        check("post_rst_first", (acks.size() > 0) ? acks[0] : 99, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
